block_pos_ctrl: RTL and testbench

//  Parametrised active-piece position controller; successor to the plain x/y/rotate register.

---
 rtl/block_pos_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_block_pos_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_pos_ctrl.sv
// Active-piece position controller (BLOCK_POS_HARD_DROP_EN adds op 5 hard drop): accept -> CHECK -> commit, 2-cycle latency.
// move_ready is high only in IDLE with no gravity drop pending; gravity wins over a waiting user move.
module block_pos_ctrl #(
   parameter int X_W        = 10,
   parameter int Y_W        = 10,
   parameter int ROT_W      = 2,
   parameter int BOARD_W    = 10,
   parameter int BOARD_H    = 20,
   parameter int SPAWN_X    = 4,
   parameter int SPAWN_Y    = 0,
   parameter int GRAV_TICKS = 50
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             err,
   input  logic             tick,
   input  logic             move_valid,
   input  logic [2:0]       move_op,
   output logic             move_ready,
   output logic             cand_valid,
   output logic [X_W-1:0]   cand_x,
   output logic [Y_W-1:0]   cand_y,
   output logic [ROT_W-1:0] cand_rot,
   input  logic             coll_hit,
   output logic [X_W-1:0]   block_pos_x,
   output logic [Y_W-1:0]   block_pos_y,
   output logic [ROT_W-1:0] rotate,
   output logic             lock_pulse,
   output logic             spawn_pulse
);

   typedef enum logic [1:0] {IDLE, CHECK, LOCK, SPAWN} state_t;

   localparam int               CNT_W   = (GRAV_TICKS > 1) ? $clog2(GRAV_TICKS) : 1;
   localparam logic [X_W-1:0]   SX      = X_W'(SPAWN_X);
   localparam logic [Y_W-1:0]   SY      = Y_W'(SPAWN_Y);
   localparam logic [X_W-1:0]   X_MAX   = X_W'(BOARD_W - 1);
   localparam logic [Y_W-1:0]   Y_MAX   = Y_W'(BOARD_H - 1);
   localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(GRAV_TICKS - 1);

   state_t             state_q, state_d;
   logic [X_W-1:0]     x_q, x_d, cand_x_q, cand_x_d;
   logic [Y_W-1:0]     y_q, y_d, cand_y_q, cand_y_d;
   logic [ROT_W-1:0]   rot_q, rot_d, cand_rot_q, cand_rot_d;
   logic               cand_valid_q, cand_valid_d;
   logic               oob_q, oob_d;
   logic               down_q, down_d;
   logic               hd_q, hd_d;
   logic               pend_q, pend_d;
   logic               lock_q, lock_d;
   logic               spawn_q, spawn_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic accept, take_grav, counting, wrap, hit;

   assign move_ready = (state_q == IDLE) && !pend_q;
   assign accept     = move_valid && move_ready;
   assign take_grav  = (state_q == IDLE) && pend_q;
   // Gravity is frozen while a piece locks/respawns and during a hard drop.
   assign counting   = ((state_q == IDLE) || (state_q == CHECK)) && !hd_q;
   assign wrap       = counting && tick && (cnt_q == CNT_TOP);
   // Out-of-range candidates behave as collisions regardless of coll_hit.
   assign hit        = oob_q || coll_hit;

   always_comb begin
      state_d      = state_q;
      x_d          = x_q;
      y_d          = y_q;
      rot_d        = rot_q;
      cand_x_d     = cand_x_q;
      cand_y_d     = cand_y_q;
      cand_rot_d   = cand_rot_q;
      cand_valid_d = cand_valid_q;
      oob_d        = oob_q;
      down_d       = down_q;
      hd_d         = hd_q;
      lock_d       = 1'b0;
      spawn_d      = 1'b0;
      cnt_d        = cnt_q;
      if (counting && tick) begin
         cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
      end
      pend_d = (pend_q && !take_grav) || wrap;

      case (state_q)
         IDLE: begin
            if (take_grav) begin
               state_d      = CHECK;
               cand_valid_d = 1'b1;
               cand_x_d     = x_q;
               cand_y_d     = y_q + Y_W'(1);
               cand_rot_d   = rot_q;
               oob_d        = (y_q >= Y_MAX);
               down_d       = 1'b1;
            end else if (accept) begin
               state_d      = CHECK;
               cand_valid_d = 1'b1;
               cand_x_d     = x_q;
               cand_y_d     = y_q;
               cand_rot_d   = rot_q;
               oob_d        = 1'b0;
               down_d       = 1'b0;
               case (move_op)
                  3'd0: begin
                     cand_x_d = x_q - X_W'(1);
                     oob_d    = (x_q == '0);
                  end
                  3'd1: begin
                     cand_x_d = x_q + X_W'(1);
                     oob_d    = (x_q >= X_MAX);
                  end
                  3'd2: begin
                     cand_y_d = y_q + Y_W'(1);
                     oob_d    = (y_q >= Y_MAX);
                     down_d   = 1'b1;
                  end
                  3'd3: cand_rot_d = rot_q + ROT_W'(1);
                  3'd4: cand_rot_d = rot_q - ROT_W'(1);
`ifdef BLOCK_POS_HARD_DROP_EN
                  3'd5: begin
                     cand_y_d = y_q + Y_W'(1);
                     oob_d    = (y_q >= Y_MAX);
                     down_d   = 1'b1;
                     hd_d     = 1'b1;
                  end
`endif
                  default: begin
                     state_d      = IDLE;
                     cand_valid_d = 1'b0;
                  end
               endcase
            end
         end
         CHECK: begin
            if (hd_q) begin
               // Hard drop keeps stepping down one row per cycle until the first hit.
               if (hit) begin
                  state_d      = LOCK;
                  lock_d       = 1'b1;
                  cand_valid_d = 1'b0;
                  hd_d         = 1'b0;
               end else begin
                  y_d      = cand_y_q;
                  cand_y_d = cand_y_q + Y_W'(1);
                  oob_d    = (cand_y_q >= Y_MAX);
               end
            end else begin
               cand_valid_d = 1'b0;
               if (hit) begin
                  if (down_q) begin
                     state_d = LOCK;
                     lock_d  = 1'b1;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  state_d = IDLE;
                  x_d     = cand_x_q;
                  y_d     = cand_y_q;
                  rot_d   = cand_rot_q;
               end
            end
         end
         LOCK: begin
            state_d    = SPAWN;
            spawn_d    = 1'b1;
            x_d        = SX;
            y_d        = SY;
            rot_d      = '0;
            cand_x_d   = SX;
            cand_y_d   = SY;
            cand_rot_d = '0;
            cnt_d      = '0;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      if (err) begin
         state_d      = IDLE;
         x_d          = SX;
         y_d          = SY;
         rot_d        = '0;
         cand_x_d     = SX;
         cand_y_d     = SY;
         cand_rot_d   = '0;
         cand_valid_d = 1'b0;
         oob_d        = 1'b0;
         down_d       = 1'b0;
         hd_d         = 1'b0;
         pend_d       = 1'b0;
         lock_d       = 1'b0;
         spawn_d      = 1'b0;
         cnt_d        = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         x_q          <= SX;
         y_q          <= SY;
         rot_q        <= '0;
         cand_x_q     <= SX;
         cand_y_q     <= SY;
         cand_rot_q   <= '0;
         cand_valid_q <= 1'b0;
         oob_q        <= 1'b0;
         down_q       <= 1'b0;
         hd_q         <= 1'b0;
         pend_q       <= 1'b0;
         lock_q       <= 1'b0;
         spawn_q      <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         y_q          <= y_d;
         rot_q        <= rot_d;
         cand_x_q     <= cand_x_d;
         cand_y_q     <= cand_y_d;
         cand_rot_q   <= cand_rot_d;
         cand_valid_q <= cand_valid_d;
         oob_q        <= oob_d;
         down_q       <= down_d;
         hd_q         <= hd_d;
         pend_q       <= pend_d;
         lock_q       <= lock_d;
         spawn_q      <= spawn_d;
         cnt_q        <= cnt_d;
      end
   end

   assign cand_valid  = cand_valid_q;
   assign cand_x      = cand_x_q;
   assign cand_y      = cand_y_q;
   assign cand_rot    = cand_rot_q;
   assign block_pos_x = x_q;
   assign block_pos_y = y_q;
   assign rotate      = rot_q;
   assign lock_pulse  = lock_q;
   assign spawn_pulse = spawn_q;

endmodule

// File: tb/tb_block_pos_ctrl.sv
// Scoreboard bench for block_pos_ctrl: a move-level board model queues expected candidates/pulses,
// a negedge monitor pops and compares them; committed position is compared after every transaction.
`timescale 1ns/1ps
module tb_block_pos_ctrl;
   localparam int BW = 10, BH = 20, GT = 2, SX = 4, SY = 0;

   logic       clk = 1'b0, rst_n = 1'b0, err = 1'b0, tick = 1'b0, move_valid = 1'b0;
   logic [2:0] move_op = 3'd0;
   logic       move_ready, cand_valid, coll_hit, lock_pulse, spawn_pulse;
   logic [9:0] cand_x, cand_y, block_pos_x, block_pos_y;
   logic [1:0] cand_rot, rotate;

   always #5 clk = ~clk;

   block_pos_ctrl #(.GRAV_TICKS(GT)) dut (
      .clk(clk), .rst_n(rst_n), .err(err), .tick(tick),
      .move_valid(move_valid), .move_op(move_op), .move_ready(move_ready),
      .cand_valid(cand_valid), .cand_x(cand_x), .cand_y(cand_y), .cand_rot(cand_rot),
      .coll_hit(coll_hit), .block_pos_x(block_pos_x), .block_pos_y(block_pos_y),
      .rotate(rotate), .lock_pulse(lock_pulse), .spawn_pulse(spawn_pulse)
   );

   typedef struct {int k; int x; int y; int r;} ev_t;   // k: 0 candidate, 1 lock, 2 spawn
   ev_t exq[$];
   int  n_chk = 0, n_pass = 0;
   int  mx = SX, my = SY, mr = 0, mt = 0;
   bit  blk [0:BW-1][0:BH-1];
   bit  rotblk [0:3];
   bit  mon_en = 1'b0;

   function automatic bit blocked(int x, int y, int r);
      if (x < 0 || x >= BW || y < 0 || y >= BH) return 1'b0;
      return blk[x][y] || (rotblk[r & 3] && (x % 2 == 1));
   endfunction

   assign coll_hit = cand_valid && blocked(int'(cand_x), int'(cand_y), int'(cand_rot));

   function automatic void push(int k, int x, int y, int r);
      ev_t e;
      e.k = k; e.x = x; e.y = y; e.r = r;
      exq.push_back(e);
   endfunction

   function automatic void model_lock();
      push(1, 0, 0, 0);
      push(2, 0, 0, 0);
      mx = SX; my = SY; mr = 0; mt = 0;
   endfunction

   function automatic void model_hard_drop();
      while (1) begin
         push(0, mx, my + 1, mr);
         if (my == BH - 1 || blocked(mx, my + 1, mr)) begin
            model_lock();
            break;
         end
         my++;
      end
   endfunction

   function automatic void model_move(int op);
      int nx = mx, ny = my, nr = mr;
      bit oob = 1'b0, dn = 1'b0;
      case (op)
         0: begin nx = mx - 1; oob = (mx == 0); end
         1: begin nx = mx + 1; oob = (mx == BW - 1); end
         2: begin ny = my + 1; oob = (my == BH - 1); dn = 1'b1; end
         3: nr = (mr + 1) % 4;
         4: nr = (mr + 3) % 4;
`ifdef BLOCK_POS_HARD_DROP_EN
         5: begin model_hard_drop(); return; end
`endif
         default: return;
      endcase
      push(0, nx & 1023, ny & 1023, nr);
      if (oob || blocked(nx, ny, nr)) begin
         if (dn) model_lock();
      end else begin
         mx = nx; my = ny; mr = nr;
      end
   endfunction

   function automatic void model_tick();
      mt++;
      if (mt == GT) begin
         mt = 0;
         model_move(2);
      end
   endfunction

   task automatic chk(string nm, int act, int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
   endtask

   task automatic fail_now(string nm);
      n_chk++;
      $display("FAIL %s", nm);
   endtask

   task automatic expect_ev(int k, int x, int y, int r);
      ev_t e;
      if (exq.size() == 0) begin
         fail_now($sformatf("unexpected_event kind=%0d x=%0d y=%0d rot=%0d", k, x, y, r));
         return;
      end
      e = exq.pop_front();
      chk("event_kind", k, e.k);
      if (k == 0 && e.k == 0) begin
         chk("cand_x", x, e.x);
         chk("cand_y", y, e.y);
         chk("cand_rot", r, e.r);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (mon_en && rst_n) begin
            if (cand_valid)  expect_ev(0, int'(cand_x), int'(cand_y), int'(cand_rot));
            if (lock_pulse)  expect_ev(1, 0, 0, 0);
            if (spawn_pulse) expect_ev(2, 0, 0, 0);
         end
      end
   end

   task automatic check_pos(string tag);
      chk({tag, "_x"}, int'(block_pos_x), mx);
      chk({tag, "_y"}, int'(block_pos_y), my);
      chk({tag, "_rot"}, int'(rotate), mr);
   endtask

   task automatic settle();
      int n = 0;
      repeat (2) @(negedge clk);
      while (!move_ready && n < 80) begin @(negedge clk); n++; end
      if (!move_ready) fail_now("settle_timeout");
   endtask

   task automatic drive_accept(int op);
      int n = 0;
      @(negedge clk);
      while (!move_ready && n < 80) begin @(negedge clk); n++; end
      if (!move_ready) fail_now("ready_timeout");
      move_valid = 1'b1;
      move_op    = 3'(op);
      model_move(op);
      @(posedge clk);
      #1 move_valid = 1'b0;
   endtask

   task automatic do_move(int op);
      drive_accept(op);
      settle();
      check_pos($sformatf("move%0d", op));
   endtask

   task automatic do_tick();
      @(negedge clk);
      tick = 1'b1;
      model_tick();
      @(negedge clk);
      tick = 1'b0;
      settle();
      check_pos("tick");
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      foreach (blk[i, j]) blk[i][j] = 1'b0;
      foreach (rotblk[i]) rotblk[i] = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_cand_valid", int'(cand_valid), 0);
      chk("rst_lock", int'(lock_pulse), 0);
      chk("rst_spawn", int'(spawn_pulse), 0);
      check_pos("rst");
      rst_n  = 1'b1;
      mon_en = 1'b1;
      @(negedge clk);
      chk("rst_move_ready", int'(move_ready), 1);

      // Left from x=1 then a left into the wall.
      repeat (3) do_move(0);
      drive_accept(0);
      @(negedge clk);
      chk("left_cand_valid", int'(cand_valid), 1);
      chk("left_cand_x_t1", int'(cand_x), 0);
      chk("left_pos_hold_t1", int'(block_pos_x), 1);
      @(negedge clk);
      chk("left_commit_t2", int'(block_pos_x), 0);
      settle();
      drive_accept(0);
      @(negedge clk);
      chk("wall_cand_valid", int'(cand_valid), 1);
      @(negedge clk);
      chk("wall_no_lock", int'(lock_pulse), 0);
      chk("wall_x_stays", int'(block_pos_x), 0);
      settle();
      check_pos("wall");

      do_move(4);
      chk("ccw_wrap_to_3", int'(rotate), 3);
      do_move(3);
      chk("cw_wrap_to_0", int'(rotate), 0);

      drive_accept(7);
      @(negedge clk);
      chk("op7_no_cand", int'(cand_valid), 0);
      chk("op7_ready", int'(move_ready), 1);
      settle();
      do_move(6);
      do_move(5);

      // err during CHECK drops the candidate and clears the gravity counter.
      do_move(1);
      do_move(1);
      do_tick();
      drive_accept(0);
      err = 1'b1;
      @(posedge clk);
      #1 err = 1'b0;
      mx = SX; my = SY; mr = 0; mt = 0;
      @(negedge clk);
      chk("err_x", int'(block_pos_x), SX);
      chk("err_y", int'(block_pos_y), SY);
      chk("err_cand_valid", int'(cand_valid), 0);
      chk("err_no_lock", int'(lock_pulse), 0);
      do_tick();

      // Gravity wins over a waiting user move.
      do_tick();
      repeat (4) do_move(2);
      @(negedge clk); tick = 1'b1; model_tick();
      @(negedge clk); model_tick();
      @(negedge clk); tick = 1'b0; move_valid = 1'b1; move_op = 3'd1;
      chk("grav_pending_ready", int'(move_ready), 0);
      @(negedge clk);
      chk("grav_cand_y", int'(cand_y), 6);
      chk("grav_check_ready", int'(move_ready), 0);
      @(negedge clk);
      chk("grav_commit_y", int'(block_pos_y), 6);
      chk("grav_then_ready", int'(move_ready), 1);
      model_move(1);
      @(posedge clk);
      #1 move_valid = 1'b0;
      settle();
      check_pos("grav_user");

      // Down at the bottom row locks then respawns.
      repeat (13) do_move(2);
      drive_accept(2);
      @(negedge clk);
      chk("bottom_cand_valid", int'(cand_valid), 1);
      chk("bottom_no_early_lock", int'(lock_pulse), 0);
      @(negedge clk);
      chk("lock_at_t2", int'(lock_pulse), 1);
      chk("no_spawn_at_t2", int'(spawn_pulse), 0);
      @(negedge clk);
      chk("spawn_at_t3", int'(spawn_pulse), 1);
      chk("lock_single", int'(lock_pulse), 0);
      chk("spawn_y", int'(block_pos_y), SY);
      chk("spawn_x", int'(block_pos_x), SX);
      settle();
      check_pos("respawn");

`ifdef BLOCK_POS_HARD_DROP_EN
      blk[SX][7] = 1'b1;
      drive_accept(5);
      begin
         int n = 0;
         while (!lock_pulse && n < 60) begin @(negedge clk); n++; end
      end
      chk("hd_lock_seen", int'(lock_pulse), 1);
      chk("hd_commit_y", int'(block_pos_y), 6);
      settle();
      check_pos("hard_drop");
      blk[SX][7] = 1'b0;
`endif

      // Asynchronous reset in the middle of a CHECK.
      do_move(1);
      do_move(3);
      drive_accept(1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_cand_valid", int'(cand_valid), 0);
      chk("arst_x", int'(block_pos_x), SX);
      chk("arst_y", int'(block_pos_y), SY);
      chk("arst_rot", int'(rotate), 0);
      mx = SX; my = SY; mr = 0; mt = 0;
      @(negedge clk);
      rst_n = 1'b1;

      for (int it = 0; it < 300; it++) begin
         int r;
         if (it % 50 == 0) begin
            foreach (blk[i, j]) blk[i][j] = ($urandom_range(0, 9) == 0);
            foreach (rotblk[i]) rotblk[i] = ($urandom_range(0, 3) == 0);
         end
         r = int'($urandom_range(0, 9));
         if (r < 2) do_tick();
         else do_move(int'($urandom_range(0, 7)));
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", exq.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
